// File: rtl/ascon_input_loader_if.sv
// Stream-in and operand-out bundle of the Ascon input loader.
// ASCON_LOADER_LAST_CHECK_EN adds in_last / frame_err.
interface ascon_input_loader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      SK;
  logic [127:0]      N;
  logic [63:0]       A;
  logic [63:0]       P;
  logic              load_valid;
  logic              load_ack;
`ifdef ASCON_LOADER_LAST_CHECK_EN
  logic              in_last;
  logic              frame_err;

  modport master (
    output in_data, in_valid, in_last, load_ack,
    input  in_ready, SK, N, A, P, load_valid, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, load_ack,
    output in_ready, SK, N, A, P, load_valid, frame_err
  );
`else
  modport master (
    output in_data, in_valid, load_ack,
    input  in_ready, SK, N, A, P, load_valid
  );

  modport slave (
    input  in_data, in_valid, load_ack,
    output in_ready, SK, N, A, P, load_valid
  );
`endif
endinterface

// File: rtl/ascon_input_loader.sv
// Ascon-128 operand loader: packs a word stream into SK/N/A/P, double-buffered.
// ASCON_LOADER_LAST_CHECK_EN enables in_last framing check with frame_err.
module ascon_input_loader #(
  parameter int DATA_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  ascon_input_loader_if.slave  bus
);

  localparam int SW        = 384;
  localparam int NUM_WORDS = SW / DATA_W;
  localparam int CW        = $clog2(NUM_WORDS);
  localparam logic [CW-1:0] LAST_W = CW'(NUM_WORDS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] shadow_q, shadow_d;
  logic [SW-1:0] out_q, out_d;

  logic xfer;
  logic last;
  logic err;
  logic complete;

  assign last = (wcnt_q == LAST_W);

  // Only the final word stalls, and only while the held frame is unacked.
  assign bus.in_ready = !(last && (state_q == FULL) && !bus.load_ack);

  assign xfer = bus.in_valid && bus.in_ready;

`ifdef ASCON_LOADER_LAST_CHECK_EN
  logic frame_err_q;

  assign err           = xfer && (bus.in_last != last);
  assign bus.frame_err = frame_err_q;
`else
  assign err = 1'b0;
`endif

  assign complete = xfer && last && !err;

  assign bus.load_valid = (state_q == FULL);
  assign bus.SK = out_q[383:256];
  assign bus.N  = out_q[255:128];
  assign bus.A  = out_q[127:64];
  assign bus.P  = out_q[63:0];

  // Shift words into the shadow frame; copy it out when a frame completes.
  always_comb begin
    wcnt_d   = wcnt_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    if (xfer) begin
      if (err) begin
        wcnt_d   = '0;
        shadow_d = '0;
      end else begin
        shadow_d = {shadow_q[SW-DATA_W-1:0], bus.in_data};
        wcnt_d   = last ? '0 : wcnt_q + CW'(1);
      end
    end
    if (complete) out_d = shadow_d;
  end

  // Output holding state: FULL while an unacknowledged frame is presented.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (complete) state_d = FULL;
      FULL:  if (!complete && bus.load_ack) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State, counter, shadow and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= EMPTY;
      wcnt_q   <= '0;
      shadow_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

`ifdef ASCON_LOADER_LAST_CHECK_EN
  // One-cycle pulse on a mis-framed transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) frame_err_q <= 1'b0;
    else     frame_err_q <= err;
  end
`endif

endmodule

// File: tb/tb_ascon_input_loader.sv
// Directed self-checking bench for ascon_input_loader at DATA_W=32.
// Table-driven stream vectors plus hand-written reset/gap/framing sequences.
module tb_ascon_input_loader;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic in_last = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  ascon_input_loader_if #(.DATA_W(32)) bus();

  ascon_input_loader #(.DATA_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

`ifdef ASCON_LOADER_LAST_CHECK_EN
  assign bus.in_last = in_last;
`endif

  typedef struct {
    logic [31:0]  d;
    logic         v;
    logic         ack;
    logic         lst;
    logic         rdy;
    logic         lv;
    logic         chk;
    logic [127:0] sk;
    logic [127:0] n;
    logic [63:0]  a;
    logic [63:0]  p;
  } vec_t;

  vec_t tbl[$];

  localparam logic [127:0] SK0 = 128'h00000000_00000001_00000002_00000003;
  localparam logic [127:0] N0  = 128'h00000004_00000005_00000006_00000007;
  localparam logic [63:0]  A0  = 64'h00000008_00000009;
  localparam logic [63:0]  P0  = 64'h0000000A_0000000B;
  localparam logic [127:0] SK1 = 128'h0000000C_0000000D_0000000E_0000000F;
  localparam logic [127:0] N1  = 128'h00000010_00000011_00000012_00000013;
  localparam logic [63:0]  A1  = 64'h00000014_00000015;
  localparam logic [63:0]  P1  = 64'h00000016_00000017;

  function automatic vec_t mk(
    input logic [31:0] d, input logic v, input logic ack,
    input logic lst, input logic rdy, input logic lv,
    input logic chk, input logic [127:0] sk, input logic [127:0] n,
    input logic [63:0] a, input logic [63:0] p
  );
    vec_t r;
    r.d = d; r.v = v; r.ack = ack; r.lst = lst;
    r.rdy = rdy; r.lv = lv; r.chk = chk;
    r.sk = sk; r.n = n; r.a = a; r.p = p;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ops(input string tag, input logic [127:0] sk,
                           input logic [127:0] n, input logic [63:0] a,
                           input logic [63:0] p);
    check({tag, ".SK"}, bus.SK, sk);
    check({tag, ".N"},  bus.N,  n);
    check({tag, ".A"},  {64'h0, bus.A}, {64'h0, a});
    check({tag, ".P"},  {64'h0, bus.P}, {64'h0, p});
  endtask

  // Drive one cycle: check in_ready before the edge, load_valid after it.
  task automatic apply(input logic [31:0] d, input logic v, input logic ack,
                       input logic lst, input logic rdy, input logic lv,
                       input string tag);
    @(negedge CLK);
    bus.in_data  = d;
    bus.in_valid = v;
    bus.load_ack = ack;
    in_last      = lst;
    #1;
    check({tag, ".in_ready"}, {127'h0, bus.in_ready}, {127'h0, rdy});
    @(posedge CLK);
    #1;
    check({tag, ".load_valid"}, {127'h0, bus.load_valid}, {127'h0, lv});
  endtask

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.load_ack = 1'b0;

    // Basic frame, no ack.
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(32'(i), 1, 0, i == 11, 1, i == 11, i == 11,
                       SK0, N0, A0, P0));
    // Next frame streams in behind the held one.
    for (int i = 12; i < 23; i++)
      tbl.push_back(mk(32'(i), 1, 0, 0, 1, 1, 1, SK0, N0, A0, P0));
    // Final word stalls while unacked.
    tbl.push_back(mk(32'h17, 1, 0, 1, 0, 1, 1, SK0, N0, A0, P0));
    tbl.push_back(mk(32'h17, 1, 0, 1, 0, 1, 1, SK0, N0, A0, P0));
    // Ack releases it: swap in the same cycle, stay FULL.
    tbl.push_back(mk(32'h17, 1, 1, 1, 1, 1, 1, SK1, N1, A1, P1));
    // Ack with no data: empties, operands kept.
    tbl.push_back(mk(32'h0, 0, 1, 0, 1, 0, 1, SK1, N1, A1, P1));
    // Ack while empty is ignored.
    tbl.push_back(mk(32'h0, 0, 1, 0, 1, 0, 1, SK1, N1, A1, P1));
    tbl.push_back(mk(32'h0, 0, 0, 0, 1, 0, 1, SK1, N1, A1, P1));

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    check("rst.in_ready", {127'h0, bus.in_ready}, 128'h1);
    check("rst.load_valid", {127'h0, bus.load_valid}, 128'h0);
    check_ops("rst", '0, '0, '0, '0);
`ifdef ASCON_LOADER_LAST_CHECK_EN
    check("rst.frame_err", {127'h0, bus.frame_err}, 128'h0);
`endif
    @(negedge CLK);
    RST = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k].d, tbl[k].v, tbl[k].ack, tbl[k].lst,
            tbl[k].rdy, tbl[k].lv, $sformatf("vec%0d", k));
      if (tbl[k].chk)
        check_ops($sformatf("vec%0d", k), tbl[k].sk, tbl[k].n,
                  tbl[k].a, tbl[k].p);
    end

    // Reset mid-frame.
    for (int i = 0; i < 5; i++)
      apply(32'hAA0 + 32'(i), 1, 0, 0, 1, 0, "pre_rst");
    @(negedge CLK);
    bus.in_valid = 1'b0;
    RST = 1'b1;
    #1;
    check("midrst.in_ready", {127'h0, bus.in_ready}, 128'h1);
    check("midrst.load_valid", {127'h0, bus.load_valid}, 128'h0);
    check_ops("midrst", '0, '0, '0, '0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 12; i++)
      apply(32'h100 + 32'(i), 1, 0, i == 11, 1, i == 11, "postrst");
    check_ops("postrst",
              128'h00000100_00000101_00000102_00000103,
              128'h00000104_00000105_00000106_00000107,
              64'h00000108_00000109, 64'h0000010A_0000010B);

    // Gapped basic frame.
    apply(0, 0, 1, 0, 1, 0, "gap_ack");
    for (int i = 0; i < 12; i++) begin
      apply(32'(i), 1, 0, i == 11, 1, i == 11, "gap");
      if (i < 11) apply(32'hDEAD, 0, 0, 0, 1, 0, "gap_idle");
    end
    check_ops("gap", SK0, N0, A0, P0);

`ifdef ASCON_LOADER_LAST_CHECK_EN
    apply(0, 0, 1, 0, 1, 0, "lc_ack");
    for (int i = 0; i < 6; i++) begin
      apply(32'h300 + 32'(i), 1, 0, i == 5, 1, 0, "lc_bad");
      if (i == 5)
        check("lc.frame_err_hi", {127'h0, bus.frame_err}, 128'h1);
    end
    apply(0, 0, 0, 0, 1, 0, "lc_idle");
    check("lc.frame_err_lo", {127'h0, bus.frame_err}, 128'h0);
    for (int i = 0; i < 12; i++)
      apply(32'h200 + 32'(i), 1, 0, i == 11, 1, i == 11, "lc_good");
    check("lc.frame_err_ok", {127'h0, bus.frame_err}, 128'h0);
    check_ops("lc_good",
              128'h00000200_00000201_00000202_00000203,
              128'h00000204_00000205_00000206_00000207,
              64'h00000208_00000209, 64'h0000020A_0000020B);
`endif

    apply(0, 0, 0, 0, 1, 1, "tail");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_input_loader.md
Name: ascon_input_loader

Overview:
- Upstream stage of the one-block Ascon-128 encrypt wrapper.
- Accepts SK, N, A and P as a stream of DATA_W-bit words over a valid/ready handshake and assembles them into full-width operand registers.
- Presents the operands with a load_valid/load_ack handshake.
- Double-buffered: the next frame can stream in while the current operands are held stable for the encrypt core.

Parameters:
- DATA_W, 32, input word width; legal values 16, 32, 64.
- NUM_WORDS, 384/DATA_W (derived localparam), words per frame (12 at DATA_W=32).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; asynchronous, active-high.
- in_data  input  DATA_W  stream word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a word this cycle.
- SK  output  128  assembled secret key.
- N  output  128  assembled nonce.
- A  output  64  assembled associated data.
- P  output  64  assembled plaintext.
- load_valid  output  1  SK/N/A/P hold a complete frame.
- load_ack  input  1  consumer has taken the current operands.

Behaviour:
- Word transfer: a word is transferred on a rising CLK edge when in_valid && in_ready.
- Frame order: SK, N, A, P, most-significant word first.
- Packing: the 384-bit shadow register {SK,N,A,P} shifts left by DATA_W and each new word enters the LSBs. At DATA_W=32 the first word ends in SK[127:96] and the last word in P[31:0].
- wcnt: 0..NUM_WORDS-1. Increments on each transfer and wraps to 0 on the transfer of word NUM_WORDS-1 (the frame-complete transfer).
- Frame complete: on that edge the shadow register is copied to the output registers SK/N/A/P and load_valid is set.
- Latency: outputs and load_valid update on the edge that accepts the final word, so they are visible the following cycle.
- Output register state machine, two states:
  - EMPTY (load_valid=0): on a frame-complete transfer, go to FULL.
  - FULL (load_valid=1):
    - load_ack with no frame-complete transfer: go to EMPTY, clear load_valid. Outputs keep their last values.
    - Frame-complete transfer with load_ack in the same cycle: stay FULL, load the new operands.
    - load_ack while in EMPTY: ignored.
- in_ready: combinational, defined as !(wcnt==NUM_WORDS-1 && load_valid && !load_ack).
  - Words 0..NUM_WORDS-2 of the next frame are always accepted.
  - Only the final word stalls while the previous frame is unacknowledged.
- Stability: SK/N/A/P never change while load_valid=1 unless a new frame completes in the same cycle as load_ack.
- Reset (asynchronous assert, any time, including mid-frame):
  - wcnt=0, shadow=0, SK=N=0, A=P=0, load_valid=0, state EMPTY.
  - in_ready evaluates to 1 immediately.
  - A partial frame is discarded. No stale words survive into the next frame.
- Idle cycles: in_valid low for any number of cycles mid-frame has no effect on the assembled result.

Optional Feature:
- Macro: ASCON_LOADER_LAST_CHECK_EN.
- When defined, two ports are added:
  - in_last (input, 1): marks the final word of a frame.
  - frame_err (output, 1): registered error pulse, reset 0.
- Error conditions, checked on each transfer:
  - in_last=1 on a word with wcnt != NUM_WORDS-1, or
  - in_last=0 on a word with wcnt == NUM_WORDS-1.
- On an error transfer:
  - wcnt returns to 0 and the frame is discarded.
  - The output registers and load_valid are not updated.
  - frame_err pulses high for exactly one cycle.
- When not defined: in_last and frame_err do not exist, and frames are delimited purely by word count.

Test Plan:
- Basic frame (DATA_W=32): words 0x00000000..0x0000000B with in_valid held high, load_ack=0. Required: one cycle after the 12th transfer, load_valid=1 with:
  - SK=0x00000000_00000001_00000002_00000003
  - N=0x00000004_00000005_00000006_00000007
  - A=0x00000008_00000009
  - P=0x0000000A_0000000B
- Back-pressure: 24 words (0x00..0x17) streamed with no load_ack.
  - Words 0..22 are accepted; in_ready=0 with word 23 pending; operands unchanged.
  - Pulse load_ack: word 23 is accepted in that cycle and load_valid stays 1.
  - Next cycle: SK=0x0000000C_0000000D_0000000E_0000000F and P=0x00000016_00000017.
- Ack then empty: after the basic frame, pulse load_ack with no new data. Required: load_valid=0 next cycle, SK..P unchanged, in_ready=1.
- Reset mid-frame: 5 words accepted, then RST asserted for 1 cycle, then words 0x100..0x10B. Required: SK=0x00000100_00000101_00000102_00000103; no trace of the first 5 words.
- Gapped input: the basic frame with in_valid toggling every other cycle. Required: same operands as the basic-frame test, and load_valid rises one cycle after the last transfer.
- With ASCON_LOADER_LAST_CHECK_EN: in_last=1 on word index 5.
  - Required: frame_err=1 for exactly one cycle and load_valid stays 0.
  - A following correctly terminated 12-word frame then loads normally.
